// File: rtl/lenet_mul_pkg.sv
// Shared widths and helpers for the LeNet shared-multiplier arbiter.
// Provides default widths, ID width helper and the round-robin pick function.
package lenet_mul_pkg;

  localparam int unsigned NumReqDef   = 4;
  localparam int unsigned AWidthDef   = 3;
  localparam int unsigned BWidthDef   = 6;
  localparam int unsigned PWidthDef   = 8;
  localparam int unsigned CntWidthDef = 16;
  localparam int unsigned MaxReq      = 8;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns the first valid index after ptr (wrapping modulo n), or -1 if none is valid.
  function automatic int rr_pick(input logic [MaxReq-1:0] valid, input int unsigned ptr,
                                 input int unsigned n);
    int          pick;
    int unsigned idx;
    pick = -1;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if ((k <= n) && (pick < 0) && valid[idx[2:0]]) pick = int'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/lenet_mul_u.sv
// Combinational unsigned multiplier; product is reduced modulo 2^P_WIDTH.
// Operands are resized to P_WIDTH first, which preserves the modular result.
module lenet_mul_u
  import lenet_mul_pkg::*;
#(
  parameter int unsigned A_WIDTH = AWidthDef,
  parameter int unsigned B_WIDTH = BWidthDef,
  parameter int unsigned P_WIDTH = PWidthDef
) (
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] p
);

  assign p = P_WIDTH'(a) * P_WIDTH'(b);

endmodule

// File: rtl/lenet_mul_share_arb.sv
// Round-robin arbiter time-sharing one multiplier among NUM_REQ requesters,
// with an operand stage (S1) and a result stage (S2) under full backpressure.
module lenet_mul_share_arb
  import lenet_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NumReqDef,
  parameter int unsigned A_WIDTH   = AWidthDef,
  parameter int unsigned B_WIDTH   = BWidthDef,
  parameter int unsigned P_WIDTH   = PWidthDef,
  parameter int unsigned CNT_WIDTH = CntWidthDef
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [P_WIDTH-1:0]         rsp_data,
  output logic                       busy,
  output logic [CNT_WIDTH-1:0]       op_count
);

  localparam int unsigned IdWidth = id_width(NUM_REQ);

  logic                 s1_v_q, s1_v_d;
  logic [IdWidth-1:0]   s1_id_q, s1_id_d;
  logic [A_WIDTH-1:0]   s1_a_q, s1_a_d;
  logic [B_WIDTH-1:0]   s1_b_q, s1_b_d;
  logic                 s2_v_q, s2_v_d;
  logic [IdWidth-1:0]   s2_id_q, s2_id_d;
  logic [P_WIDTH-1:0]   s2_p_q, s2_p_d;
  logic [IdWidth-1:0]   ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 s2_free, s1_adv, accept_en, req_hs, rsp_hs;
  logic [NUM_REQ-1:0]   grant_oh, s2_oh;
  logic [IdWidth-1:0]   win_id;
  logic [A_WIDTH-1:0]   win_a;
  logic [B_WIDTH-1:0]   win_b;
  logic [P_WIDTH-1:0]   mul_p;
  int                   win_idx;

  lenet_mul_u #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) u_mul (
    .a (s1_a_q),
    .b (s1_b_q),
    .p (mul_p)
  );

  // Pipeline flow control; rsp_ready of non-owning requesters is masked out by s2_oh.
  always_comb begin
    s2_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s2_oh[i] = (s2_id_q == IdWidth'(i));
    end
    rsp_hs    = s2_v_q & (|(rsp_ready & s2_oh));
    s2_free   = ~s2_v_q | rsp_hs;
    s1_adv    = s1_v_q & s2_free;
    accept_en = ~s1_v_q | s1_adv;
  end

  // Round-robin grant and operand select for the winning requester.
  always_comb begin
    win_idx  = rr_pick(MaxReq'(req_valid), 32'(ptr_q), NUM_REQ);
    grant_oh = '0;
    win_id   = '0;
    win_a    = '0;
    win_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == i) begin
        grant_oh[i] = 1'b1;
        win_id      = IdWidth'(i);
        win_a       = req_a[i*A_WIDTH +: A_WIDTH];
        win_b       = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  // Reset gates the grant so no handshake is offered while the block is held in reset.
  assign req_ready = grant_oh & {NUM_REQ{accept_en & ap_rst_n}};
  assign req_hs    = |req_ready;

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_id_d = s1_id_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    if (req_hs) begin
      s1_v_d  = 1'b1;
      s1_id_d = win_id;
      s1_a_d  = win_a;
      s1_b_d  = win_b;
    end else if (s1_adv) begin
      s1_v_d  = 1'b0;
    end
  end

  always_comb begin
    s2_v_d  = s2_v_q;
    s2_id_d = s2_id_q;
    s2_p_d  = s2_p_q;
    if (s1_adv) begin
      s2_v_d  = 1'b1;
      s2_id_d = s1_id_q;
      s2_p_d  = mul_p;
    end else if (rsp_hs) begin
      s2_v_d  = 1'b0;
    end
  end

  always_comb begin
    ptr_d = req_hs ? win_id : ptr_q;
    cnt_d = cnt_q + CNT_WIDTH'(rsp_hs);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_v_q  <= 1'b0;
      s1_id_q <= '0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s2_v_q  <= 1'b0;
      s2_id_q <= '0;
      s2_p_q  <= '0;
      ptr_q   <= IdWidth'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_id_q <= s1_id_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s2_v_q  <= s2_v_d;
      s2_id_q <= s2_id_d;
      s2_p_q  <= s2_p_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = s2_v_q ? s2_oh : '0;
  assign rsp_data  = s2_p_q;
  assign busy      = s1_v_q | s2_v_q;
  assign op_count  = cnt_q;

endmodule

// File: doc/lenet_mul_share_arb.md
Name: lenet_mul_share_arb

Overview:
Round-robin arbiter and pipeline controller that time-shares one unsigned 3x6-bit multiplier among several requesters in the LeNet accelerator datapath. Each requester presents operands with a valid/ready handshake and receives its product on a shared result bus, tagged by a one-hot valid. Two register stages decouple arbitration from result return and provide full backpressure. The block sits between the conv/pool engines and the shared multiplier resource.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
A_WIDTH, 3, operand A width, unsigned
B_WIDTH, 6, operand B width, unsigned
P_WIDTH, 8, product width; result = (a*b) mod 2^P_WIDTH
CNT_WIDTH, 16, completed-operation counter width

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  one-hot grant; handshake when valid&ready
req_a  in  NUM_REQ*A_WIDTH  packed operand A, requester i at [i*A_WIDTH +: A_WIDTH]
req_b  in  NUM_REQ*B_WIDTH  packed operand B, same packing
rsp_valid  out  NUM_REQ  one-hot result valid for owning requester
rsp_ready  in  NUM_REQ  per-requester result accept
rsp_data  out  P_WIDTH  shared product bus
busy  out  1  high when either pipeline stage holds an operation
op_count  out  CNT_WIDTH  count of completed response handshakes, wraps

Behaviour:
- Reset (ap_rst_n=0, asynchronous): s1_v, s2_v=0; req_ready=0, rsp_valid=0, rsp_data=0, busy=0, op_count=0; RR pointer=NUM_REQ-1 (requester 0 has first priority). In-flight ops dropped, no response issued.
- Stage S1 (operand reg): s1_v, s1_id, s1_a, s1_b. Stage S2 (result reg): s2_v, s2_id, s2_p.
- s2_free = !s2_v | rsp_ready[s2_id]. s1_adv = s1_v & s2_free. accept_en = !s1_v | s1_adv.
- Grant: combinational round-robin over req_valid, starting at pointer+1 mod NUM_REQ; req_ready = onehot(winner) & {NUM_REQ{accept_en}}; all zero if no valid or !accept_en. Requesters must not make req_valid depend on req_ready.
- On handshake: S1 loads winner's id/a/b, s1_v=1, pointer<=winner. Pointer changes only on handshake.
- On s1_adv: S2 loads s2_id=s1_id, s2_p=mul(s1_a,s1_b) truncated to P_WIDTH, s2_v=1. If S1 not refilled that cycle, s1_v<=0.
- If s2_v & rsp_ready[s2_id] and no s1_adv: s2_v<=0.
- rsp_valid = s2_v ? onehot(s2_id) : 0; rsp_data = s2_p (held stable while rsp_valid and not accepted). rsp_ready of non-owning requesters ignored.
- Latency: handshake at edge k -> rsp_valid high after edge k+1 (two cycles). Throughput: 1 op/cycle with no backpressure.
- Backpressure: S2 stalled -> S1 holds; S1 full and stalled -> req_ready all 0. No op lost or duplicated.
- op_count increments on each response handshake (s2_v & rsp_ready[s2_id]); wraps 2^CNT_WIDTH-1 -> 0.
- busy = s1_v | s2_v.
- Operand packing is LSB-first per requester; unused products beyond P_WIDTH discarded silently.

Decomposition:
- Package lenet_mul_pkg: default widths (A=3, B=6, P=8), NUM_REQ default, ID_WIDTH = $clog2(NUM_REQ) (min 1), round-robin priority function.
- Sub-module lenet_mul_u: purely combinational unsigned A_WIDTH x B_WIDTH -> P_WIDTH multiplier (zero-extended operands, truncated product), instantiated once in S1->S2 path.

Test Plan:
- Single op: req 0 a=5 b=12, rsp_ready=1 -> rsp_valid=4'b0001 two cycles after handshake, rsp_data=60, op_count=1, busy low afterwards.
- Truncation: req 2 a=7 b=63 -> rsp_data=185 (441 mod 256), rsp_valid=4'b0100; a=0 b=63 -> 0.
- Fairness: all 4 valid continuously with distinct operands, rsp_ready=all 1 -> grants 0,1,2,3,0,1... one per cycle, each product correct and tagged to right requester, op_count=8 after 8 results.
- Backpressure: req 1 a=3 b=10, req 3 a=2 b=9; rsp_ready[1]=0 for 5 cycles -> rsp_valid=4'b0010, rsp_data=30 stable, req_ready=0 once S1 full; release -> 30 then 18 delivered, none lost.
- Reset mid-op: assert ap_rst_n=0 with S1 and S2 full -> all outputs 0 immediately; after release req 0 granted first; no stale response.
- Counter wrap: complete 65536 ops -> op_count returns to 0, next op -> 1.
